// File: rtl/cmd_bus_pkg.sv
// rtl/cmd_bus_pkg.sv - shared state encoding and bus width defaults for the cmd bus arbiter
package cmd_bus_pkg;

  localparam int unsigned CMD_ADDR_W = 24;
  localparam int unsigned CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT0  = 2'd1,
    ST_GRANT1  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/cmd_bus_arbiter.sv
// rtl/cmd_bus_arbiter.sv - two-requester round-robin arbiter onto the mib master cmd slave port
module cmd_bus_arbiter
  import cmd_bus_pkg::*;
#(
  parameter int unsigned P_ADDR_W             = CMD_ADDR_W,
  parameter int unsigned P_DATA_W             = CMD_DATA_W,
  parameter int unsigned P_GRANT_TIMEOUT_CLKS = 64
) (
  input  logic                tb_clk,
  input  logic                tb_srst,

  input  logic                i_m0_sel,
  input  logic                i_m0_rd_wr_n,
  input  logic [P_ADDR_W-1:0] i_m0_byte_addr,
  input  logic [P_DATA_W-1:0] i_m0_wdata,
  output logic                o_m0_ack,
  output logic [P_DATA_W-1:0] o_m0_rdata,
  output logic                o_m0_timeout,

  input  logic                i_m1_sel,
  input  logic                i_m1_rd_wr_n,
  input  logic [P_ADDR_W-1:0] i_m1_byte_addr,
  input  logic [P_DATA_W-1:0] i_m1_wdata,
  output logic                o_m1_ack,
  output logic [P_DATA_W-1:0] o_m1_rdata,
  output logic                o_m1_timeout,

  output logic                o_cmd_sel,
  output logic                o_cmd_rd_wr_n,
  output logic [P_ADDR_W-1:0] o_cmd_byte_addr,
  output logic [P_DATA_W-1:0] o_cmd_wdata,
  input  logic                i_cmd_ack,
  input  logic [P_DATA_W-1:0] i_cmd_rdata,
  input  logic                i_cmd_mib_timeout
);

  localparam int unsigned       WDOG_W    = (P_GRANT_TIMEOUT_CLKS > 2) ? $clog2(P_GRANT_TIMEOUT_CLKS) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(P_GRANT_TIMEOUT_CLKS - 1);

  arb_state_e        state_q;
  logic              last_m1_q;
  logic [WDOG_W-1:0] wdog_q;

  logic              grant_m1_d;
  logic              req_any;
  logic              wdog_expired;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_m1_d   = 1'b0;
    if (i_m0_sel && i_m1_sel) begin
      grant_m1_d = ~last_m1_q;
    end else begin
      grant_m1_d = i_m1_sel;
    end
    req_any      = i_m0_sel | i_m1_sel;
    wdog_expired = (wdog_q == WDOG_LAST);
  end

  always_ff @(posedge tb_clk or negedge tb_srst) begin
    if (!tb_srst) begin
      state_q         <= ST_IDLE;
      last_m1_q       <= 1'b1;
      wdog_q          <= '0;
      o_cmd_sel       <= 1'b0;
      o_cmd_rd_wr_n   <= 1'b0;
      o_cmd_byte_addr <= '0;
      o_cmd_wdata     <= '0;
      o_m0_ack        <= 1'b0;
      o_m0_timeout    <= 1'b0;
      o_m0_rdata      <= '0;
      o_m1_ack        <= 1'b0;
      o_m1_timeout    <= 1'b0;
      o_m1_rdata      <= '0;
    end else begin
      o_m0_ack     <= 1'b0;
      o_m1_ack     <= 1'b0;
      o_m0_timeout <= 1'b0;
      o_m1_timeout <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            state_q         <= grant_m1_d ? ST_GRANT1 : ST_GRANT0;
            last_m1_q       <= grant_m1_d;
            wdog_q          <= '0;
            o_cmd_sel       <= 1'b1;
            o_cmd_rd_wr_n   <= grant_m1_d ? i_m1_rd_wr_n   : i_m0_rd_wr_n;
            o_cmd_byte_addr <= grant_m1_d ? i_m1_byte_addr : i_m0_byte_addr;
            o_cmd_wdata     <= grant_m1_d ? i_m1_wdata     : i_m0_wdata;
          end
        end

        // The latched o_cmd_rd_wr_n decides whether read data is captured,
        // so a requester changing its inputs mid-grant cannot corrupt it.
        ST_GRANT0, ST_GRANT1: begin
          if (i_cmd_ack) begin
            o_cmd_sel <= 1'b0;
            state_q   <= ST_RELEASE;
            if (state_q == ST_GRANT0) begin
              o_m0_ack <= 1'b1;
              if (o_cmd_rd_wr_n) begin
                o_m0_rdata <= i_cmd_rdata;
              end
            end else begin
              o_m1_ack <= 1'b1;
              if (o_cmd_rd_wr_n) begin
                o_m1_rdata <= i_cmd_rdata;
              end
            end
          end else if (i_cmd_mib_timeout || wdog_expired) begin
            o_cmd_sel <= 1'b0;
            state_q   <= ST_RELEASE;
            if (state_q == ST_GRANT0) begin
              o_m0_timeout <= 1'b1;
            end else begin
              o_m1_timeout <= 1'b1;
            end
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end

        ST_RELEASE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cmd_bus_arbiter.md
CMD_BUS_ARBITER -- requirements
Module: cmd_bus_arbiter

Interface
REQ-001 SHALL have parameter P_ADDR_W, default 24, cmd bus byte-address width.
REQ-002 SHALL have parameter P_DATA_W, default 32, cmd bus data width.
REQ-003 SHALL have parameter P_GRANT_TIMEOUT_CLKS, default 64, watchdog limit per granted transaction; it SHALL exceed the downstream MIB ACK timeout.
REQ-004 SHALL have port tb_clk  in  1  clock; all logic is rising-edge.
REQ-005 SHALL have port tb_srst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports i_mN_sel / i_mN_rd_wr_n (N=0,1)  in  1  requester N select / read(1)-write(0).
REQ-007 SHALL have ports i_mN_byte_addr  in  P_ADDR_W and i_mN_wdata  in  P_DATA_W  requester N address/write data.
REQ-008 SHALL have ports o_mN_ack  out  1, o_mN_rdata  out  P_DATA_W, o_mN_timeout  out  1  requester N completion, read data, failure.
REQ-009 SHALL have ports o_cmd_sel, o_cmd_rd_wr_n  out  1; o_cmd_byte_addr  out  P_ADDR_W; o_cmd_wdata  out  P_DATA_W  toward mib master cmd slave.
REQ-010 SHALL have ports i_cmd_ack  in  1, i_cmd_rdata  in  P_DATA_W, i_cmd_mib_timeout  in  1  from mib master.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT0, GRANT1, RELEASE.
REQ-012 IDLE: single request SHALL go to its GRANTn next edge; simultaneous requests SHALL grant the requester not granted last; after reset, m0 wins.
REQ-013 On IDLE->GRANTn, SHALL latch i_mN_rd_wr_n/byte_addr/wdata and drive them on o_cmd_* unchanged for the whole grant, with o_cmd_sel=1 starting the GRANTn cycle.
REQ-014 In GRANTn, on i_cmd_ack=1: o_cmd_sel=0, o_mN_ack=1 for exactly one cycle, o_mN_rdata=i_cmd_rdata (reads; held until next read completion for N), state -> RELEASE.
REQ-015 In GRANTn, on i_cmd_mib_timeout=1 without ack: o_cmd_sel=0, o_mN_timeout=1 one cycle, no ack, -> RELEASE.
REQ-016 i_cmd_ack and i_cmd_mib_timeout together SHALL be treated as ack; timeout not reported.
REQ-017 Watchdog counter SHALL clear on grant, increment each GRANTn cycle; on reaching P_GRANT_TIMEOUT_CLKS-1 SHALL behave as REQ-015.
REQ-018 RELEASE SHALL last exactly one cycle, ignore all sel inputs, then -> IDLE; min gap between downstream transactions = 2 idle cycles.
REQ-019 Requester dropping i_mN_sel mid-grant SHALL NOT abort; transaction completes and ack is still pulsed.
REQ-020 Non-granted requester SHALL see o_mN_ack=0, o_mN_timeout=0; its request waits (sel held).
REQ-021 ack/timeout for N SHALL never assert in same cycle, nor for both requesters in same cycle.
REQ-022 Latency: o_mN_ack SHALL rise one cycle after i_cmd_ack sampled high; o_cmd_sel one cycle after i_mN_sel sampled high in IDLE.

Reset
REQ-023 tb_srst=0 SHALL immediately force IDLE, last-grant=m1 (so m0 priority), watchdog=0, all outputs 0 incl. rdata.
REQ-024 Reset mid-grant SHALL abandon transaction with no ack/timeout pulse; after release first edge is IDLE.

Structure
REQ-025 State enum, P_ADDR_W/P_DATA_W defaults SHALL live in shared package cmd_bus_pkg.
REQ-026 No sub-module; FSM, round-robin pointer, latches, watchdog inline.

Verification
REQ-027 m0 write 0x000004 data 0x03030404, ack 3 cycles later -> o_cmd_* match, o_m0_ack one cycle, o_m1_* idle.
REQ-028 m0,m1 reads same cycle, m1 last granted -> m0 first; downstream rdata 0xA5A5A5A5 then 0x5A5A5A5A -> o_m0_rdata=0xA5A5A5A5, o_m1_rdata=0x5A5A5A5A, ≥2-cycle gap.
REQ-029 m1 write, i_cmd_mib_timeout pulse after 32 cycles -> o_m1_timeout one cycle, o_m1_ack never, o_cmd_sel 0 next cycle.
REQ-030 m0 read, no ack/timeout -> o_m0_timeout at grant cycle 64, FSM IDLE two cycles later.
REQ-031 tb_srst low mid-grant -> all outputs 0 immediately, no ack; after release next m1 request granted normally.
REQ-032 m0 continuous requests while m1 requests -> strict alternation m0,m1,m0,m1.
